// File: rtl/fetch_seq_pkg.sv
// Shared constants for the instruction-fetch sequencer: opcodes, next-PC source codes, FSM states.
package fetch_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [4:0] RS_RA = 5'd31;

  localparam logic [1:0] PCSEL_JUMP   = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JR     = 2'b10;
  localparam logic [1:0] PCSEL_SERIAL = 2'b11;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump, jr $31, conditional branch or serial PC+4.
module fetch_next_pc
  import fetch_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_reg31,
  input  logic        i_taken,
  output logic [31:0] o_pc,
  output logic [1:0]  o_pc_sel
);

  logic        [31:0] w_plus4;
  logic signed [31:0] w_off;
  logic        [5:0]  w_op;
  logic        [4:0]  w_rs;

  assign w_plus4 = i_pc + 32'd4;
  assign w_off   = signed'({{14{i_inst[15]}}, i_inst[15:0], 2'b00});
  assign w_op    = i_inst[31:26];
  assign w_rs    = i_inst[25:21];

  always_comb begin
    o_pc     = w_plus4;
    o_pc_sel = PCSEL_SERIAL;
    if ((w_op == OP_J) || (w_op == OP_JAL)) begin
      o_pc     = {w_plus4[31:28], i_inst[25:0], 2'b00};
      o_pc_sel = PCSEL_JUMP;
    end else if ((w_op == OP_RTYPE) && (w_rs == RS_RA)) begin
      o_pc     = i_reg31;
      o_pc_sel = PCSEL_JR;
    end else if (is_branch(w_op) && i_taken) begin
      o_pc     = w_plus4 + $unsigned(w_off);
      o_pc_sel = PCSEL_BRANCH;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch -> issue -> branch-resolve controller owning the PC, with memory-timeout fault.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        cmp_valid,
  input  logic        Zero,
  input  logic [31:0] reg31,
  output logic [1:0]  pc_sel,
  output logic        fault,
  output logic [31:0] inst_count,
  output logic [31:0] taken_count
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_wait;
  logic          r_req;
  logic          r_valid;
  logic [31:0]   r_inst;
  logic [31:0]   r_ipc;
  logic [1:0]    r_sel;
  logic          r_fault;

  logic          w_hs;
  logic          w_is_br;
  logic          w_taken;
  logic          w_resolve;
  logic [31:0]   w_npc;
  logic [1:0]    w_nsel;

  assign w_hs      = (r_state == ST_ISSUE) && inst_ready;
  assign w_is_br   = is_branch(r_inst[31:26]);
  assign w_taken   = ((r_inst[31:26] == OP_BEQ) && Zero) || ((r_inst[31:26] == OP_BNE) && !Zero);
  assign w_resolve = (r_state == ST_RESOLVE) && cmp_valid;

  fetch_next_pc u_next_pc (
    .i_pc     (r_pc),
    .i_inst   (r_inst),
    .i_reg31  (reg31),
    .i_taken  (w_taken),
    .o_pc     (w_npc),
    .o_pc_sel (w_nsel)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack)                           w_state_nxt = ST_ISSUE;
        else if (r_wait == CW'(TIMEOUT - 1))    w_state_nxt = ST_FAULT;
      end
      ST_ISSUE:   if (w_hs) w_state_nxt = w_is_br ? ST_RESOLVE : ST_FETCH;
      ST_RESOLVE: if (cmp_valid) w_state_nxt = ST_FETCH;
      default:    w_state_nxt = ST_FAULT;
    endcase
  end

  // Outputs are registered from the next state so the reset cycle never shows a request.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_wait  <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_inst  <= 32'h0;
      r_ipc   <= 32'h0;
      r_sel   <= PCSEL_SERIAL;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == ST_FETCH);
      r_valid <= (w_state_nxt == ST_ISSUE);
      r_fault <= (w_state_nxt == ST_FAULT);
      if (r_state == ST_FETCH) begin
        if (imem_ack) begin
          r_inst <= imem_rdata;
          r_ipc  <= r_pc;
          r_wait <= '0;
        end else begin
          r_wait <= r_wait + CW'(1);
        end
      end
      if ((w_hs && !w_is_br) || w_resolve) begin
        r_pc  <= w_npc;
        r_sel <= w_nsel;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_icnt;
  logic [31:0] r_tcnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_icnt <= 32'h0;
      r_tcnt <= 32'h0;
    end else begin
      if (w_hs) r_icnt <= r_icnt + 32'd1;
      if ((w_hs && !w_is_br && (w_nsel != PCSEL_SERIAL)) || (w_resolve && w_taken))
        r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign inst_count  = r_icnt;
  assign taken_count = r_tcnt;
`else
  assign inst_count  = 32'h0;
  assign taken_count = 32'h0;
`endif

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign inst_valid = r_valid;
  assign inst_out   = r_inst;
  assign inst_pc    = r_ipc;
  assign pc_sel     = r_sel;
  assign fault      = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table of instructions plus multi-cycle corner sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        cmp_valid;
  logic        Zero;
  logic [31:0] reg31;
  logic [1:0]  pc_sel;
  logic        fault;
  logic [31:0] inst_count;
  logic [31:0] taken_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .Clock       (clk),
    .Reset       (Reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .cmp_valid   (cmp_valid),
    .Zero        (Zero),
    .reg31       (reg31),
    .pc_sel      (pc_sel),
    .fault       (fault),
    .inst_count  (inst_count),
    .taken_count (taken_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] r31;
    logic        zero;
    int          dly;
    logic [31:0] ipc;
    logic [31:0] nxt;
    logic [1:0]  sel;
  } vec_t;

  vec_t tv[13];
  vec_t pv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; imem_ack = 1'b1; cmp_valid = 1'b1; Zero = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    Reset = 1'b0; imem_ack = 1'b0; cmp_valid = 1'b0; Zero = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".req"},   {31'h0, imem_req},   32'h0);
    chk({tag, ".addr"},  imem_addr,           32'h0);
    chk({tag, ".valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, ".inst"},  inst_out,            32'h0);
    chk({tag, ".ipc"},   inst_pc,             32'h0);
    chk({tag, ".sel"},   {30'h0, pc_sel},     32'h3);
    chk({tag, ".fault"}, {31'h0, fault},      32'h0);
    chk({tag, ".icnt"},  inst_count,          32'h0);
    chk({tag, ".tcnt"},  taken_count,         32'h0);
  endtask

  // Assumes the DUT is in FETCH; runs one instruction through issue (and resolve for branches).
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    repeat (v.dly) @(negedge clk);
    chk({tag, ".req"},  {31'h0, imem_req}, 32'h1);
    chk({tag, ".addr"}, imem_addr, v.ipc);
    imem_ack = 1'b1; imem_rdata = v.inst;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    chk({tag, ".valid"}, {31'h0, inst_valid}, 32'h1);
    chk({tag, ".inst"},  inst_out, v.inst);
    chk({tag, ".ipc"},   inst_pc, v.ipc);
    reg31 = v.r31; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0; reg31 = 32'hDEAD_BEEF;
    if (v.inst[31:27] == 5'b00010) begin
      chk({tag, ".rsv_valid"}, {31'h0, inst_valid}, 32'h0);
      @(negedge clk);
      chk({tag, ".rsv_addr"}, imem_addr, v.ipc);
      cmp_valid = 1'b1; Zero = v.zero;
      @(negedge clk);
      cmp_valid = 1'b0; Zero = 1'b0;
    end
    chk({tag, ".nxt_addr"}, imem_addr, v.nxt);
    chk({tag, ".nxt_sel"},  {30'h0, pc_sel}, {30'h0, v.sel});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    cmp_valid = 1'b0; Zero = 1'b0; reg31 = 32'h0;

    tv[0]  = '{32'h2008_0005, 32'h0,         1'b0, 3, 32'h0000_0000, 32'h0000_0004, 2'b11};
    tv[1]  = '{32'h0800_0004, 32'h0,         1'b0, 0, 32'h0000_0004, 32'h0000_0010, 2'b00};
    tv[2]  = '{32'h1000_FFFF, 32'h0,         1'b1, 1, 32'h0000_0010, 32'h0000_0010, 2'b01};
    tv[3]  = '{32'h1000_FFFF, 32'h0,         1'b0, 2, 32'h0000_0010, 32'h0000_0014, 2'b11};
    tv[4]  = '{32'h1400_0002, 32'h0,         1'b0, 0, 32'h0000_0014, 32'h0000_0020, 2'b01};
    tv[5]  = '{32'h0800_0040, 32'h0,         1'b0, 1, 32'h0000_0020, 32'h0000_0100, 2'b00};
    tv[6]  = '{32'h03E0_0008, 32'h0000_0080, 1'b0, 0, 32'h0000_0100, 32'h0000_0080, 2'b10};
    tv[7]  = '{32'h0FFF_FFFF, 32'h0,         1'b0, 2, 32'h0000_0080, 32'h0FFF_FFFC, 2'b00};
    tv[8]  = '{32'h0000_0000, 32'h0,         1'b0, 0, 32'h0FFF_FFFC, 32'h1000_0000, 2'b11};
    tv[9]  = '{32'h03E0_0008, 32'hFFFF_FFFC, 1'b0, 1, 32'h1000_0000, 32'hFFFF_FFFC, 2'b10};
    tv[10] = '{32'h2008_0005, 32'h0,         1'b0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 2'b11};
    tv[11] = '{32'h1400_0010, 32'h0,         1'b1, 1, 32'h0000_0000, 32'h0000_0004, 2'b11};
    tv[12] = '{32'h1000_0003, 32'h0,         1'b1, 0, 32'h0000_0004, 32'h0000_0014, 2'b01};

    pv[0] = '{32'h2008_0005, 32'h0, 1'b0, 1, 32'h0000_0000, 32'h0000_0004, 2'b11};
    pv[1] = '{32'h1400_0002, 32'h0, 1'b0, 0, 32'h0000_0004, 32'h0000_0010, 2'b01};
    pv[2] = '{32'h0C00_0008, 32'h0, 1'b0, 0, 32'h0000_0010, 32'h0000_0020, 2'b00};
    pv[3] = '{32'h2008_0005, 32'h0, 1'b0, 0, 32'h0000_0020, 32'h0000_0024, 2'b11};

    // Reset values, then the instruction table as one continuous program.
    do_reset();
    chk_reset_state("rst0");
    for (int i = 0; i < 13; i++) apply(tv[i], i);
`ifdef FETCH_PERF_EN
    chk("tbl.icnt", inst_count, 32'd13);
    chk("tbl.tcnt", taken_count, 32'd8);
`else
    chk("tbl.icnt", inst_count, 32'd0);
    chk("tbl.tcnt", taken_count, 32'd0);
`endif

    // Perf program: addi, taken bne, jal, addi.
    do_reset();
    chk_reset_state("rst1");
    for (int i = 0; i < 4; i++) apply(pv[i], 100 + i);
`ifdef FETCH_PERF_EN
    chk("perf.icnt", inst_count, 32'd4);
    chk("perf.tcnt", taken_count, 32'd2);
`else
    chk("perf.icnt", inst_count, 32'd0);
    chk("perf.tcnt", taken_count, 32'd0);
`endif

    // Downstream stall: ack and cmp_valid noise during ISSUE must not disturb the held instruction.
    do_reset();
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; cmp_valid = 1'b1; Zero = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.valid", c), {31'h0, inst_valid}, 32'h1);
      chk($sformatf("stall%0d.inst", c), inst_out, 32'h2008_0005);
      chk($sformatf("stall%0d.ipc", c), inst_pc, 32'h0);
      chk($sformatf("stall%0d.addr", c), imem_addr, 32'h0);
    end
    imem_ack = 1'b0; cmp_valid = 1'b0; Zero = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("stall.nxt_addr", imem_addr, 32'h4);
    chk("stall.nxt_sel", {30'h0, pc_sel}, 32'h3);

    // Reset while waiting in RESOLVE, with a compare result pending in the reset cycle.
    imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
    @(negedge clk);
    imem_ack = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("rsv.valid", {31'h0, inst_valid}, 32'h0);
    do_reset();
    chk_reset_state("rst_rsv");
    @(negedge clk);
    chk("rsv.req_after", {31'h0, imem_req}, 32'h1);
    chk("rsv.addr_after", imem_addr, 32'h0);

    // Memory timeout: 16 cycles in FETCH without ack.
    do_reset();
    repeat (15) @(negedge clk);
    chk("to.fault15", {31'h0, fault}, 32'h0);
    chk("to.req15", {31'h0, imem_req}, 32'h1);
    @(negedge clk);
    chk("to.fault16", {31'h0, fault}, 32'h1);
    chk("to.req16", {31'h0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005; inst_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; inst_ready = 1'b0;
    chk("to.sticky", {31'h0, fault}, 32'h1);
    chk("to.valid", {31'h0, inst_valid}, 32'h0);
    do_reset();
    chk_reset_state("rst_to");

    // An ack on the last allowed FETCH cycle still wins over the fault.
    repeat (15) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0004;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("edge.fault", {31'h0, fault}, 32'h0);
    chk("edge.valid", {31'h0, inst_valid}, 32'h1);
    chk("edge.inst", inst_out, 32'h0800_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
